// File: rtl/gpio_out_pkg.sv
// gpio_out_pkg
// Shared definitions for the GPIO output register bank:
//   - write-mode encodings (load / set / clear / toggle)
//   - default bank geometry and blink half-period
//   - lane_bit(): per-bit write result, applied bit-by-bit so it works
//     for any lane width without a width-fixed function signature
package gpio_out_pkg;

    localparam logic [1:0] WR_LOAD = 2'b00;
    localparam logic [1:0] WR_SET  = 2'b01;
    localparam logic [1:0] WR_CLR  = 2'b10;
    localparam logic [1:0] WR_TGL  = 2'b11;

    localparam int DEF_LANES     = 4;
    localparam int DEF_LANE_W    = 8;
    localparam int DEF_BLINK_DIV = 25_000_000;

    // New value of one lane bit given its old value, the operand bit and the mode
    function automatic logic lane_bit(input logic oldBit,
                                      input logic dataBit,
                                      input logic [1:0] mode);
        logic r;
        unique case (mode)
            WR_LOAD: r = dataBit;
            WR_SET:  r = oldBit | dataBit;
            WR_CLR:  r = oldBit & ~dataBit;
            default: r = oldBit ^ dataBit;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gpio_blink_tick.sv
// gpio_blink_tick
// Free-running blink phase generator. A counter runs 0..DIV-1; on the wrap
// cycle it returns to 0 and the phase flips, giving a period of 2*DIV cycles.
// Ports:
//   CLOCK_50  in   system clock (rising edge)
//   reset     in   synchronous active-high reset, clears counter and phase
//   phase     out  current blink phase
module gpio_blink_tick #(
    parameter int DIV = 25_000_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic phase
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] count_q, count_d;
    logic          phase_q, phase_d;
    logic          wrap;

    // Next-state: count up, wrap at DIV-1 and flip the phase on the wrap cycle
    always_comb begin
        wrap    = (count_q == CW'(DIV - 1));
        count_d = wrap ? '0 : count_q + CW'(1);
        phase_d = wrap ? ~phase_q : phase_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            count_q <= '0;
            phase_q <= 1'b0;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/gpio_out_bank.sv
// gpio_out_bank
// Multi-lane GPIO output register bank. Each rising edge of wr_req commits one
// write (load/set/clear/toggle) to the selected lane. An optional preview
// shows the pending result on the selected lane before commit, and an
// optional per-lane blink engine blanks masked lanes during blink phase 1.
// Build option: define GPIO_OUT_BLINK_EN to include the blink engine;
// without it blink_phase is 0 and blink_mask is ignored.
// Ports:
//   CLOCK_50     in   system clock (rising edge)
//   reset        in   synchronous active-high reset
//   lane_sel     in   target lane of the write
//   wr_data      in   write operand
//   wr_mode      in   00 load, 01 set, 10 clear, 11 toggle
//   wr_req       in   level request, each rising edge commits one write
//   preview_en   in   show pending result on the selected lane
//   blink_mask   in   per-lane blink enable
//   gpio_out     out  lane k at bits [k*LANE_W +: LANE_W]
//   commit       out  one-cycle pulse per accepted write
//   blink_phase  out  current blink phase
module gpio_out_bank
    import gpio_out_pkg::*;
#(
    parameter  int LANES     = DEF_LANES,
    parameter  int LANE_W    = DEF_LANE_W,
    parameter  int BLINK_DIV = DEF_BLINK_DIV,
    localparam int SEL_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        lane_sel,
    input  logic [LANE_W-1:0]       wr_data,
    input  logic [1:0]              wr_mode,
    input  logic                    wr_req,
    input  logic                    preview_en,
    input  logic [LANES-1:0]        blink_mask,
    output logic [LANES*LANE_W-1:0] gpio_out,
    output logic                    commit,
    output logic                    blink_phase
);

    logic [LANE_W-1:0] lane_q [LANES];
    logic [LANE_W-1:0] lane_d [LANES];
    logic              wrReq_q;
    logic              commit_q, commit_d;
    logic              rise;
    logic              selValid;
    logic [LANE_W-1:0] curLane;
    logic [LANE_W-1:0] res;
    logic [LANES-1:0]  blankLane;

    // Pending result for the selected lane. The lane is picked with a compare
    // loop so an out-of-range select reads 0 instead of indexing past the array.
    always_comb begin
        selValid = (32'(lane_sel) < LANES);
        curLane  = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_sel == SEL_W'(k)) curLane = lane_q[k];
        end
        res = '0;
        for (int b = 0; b < LANE_W; b++) begin
            res[b] = lane_bit(curLane[b], wr_data[b], wr_mode);
        end
    end

    // Commit on the request's rising edge; out-of-range writes are dropped
    always_comb begin
        rise     = wr_req & ~wrReq_q;
        commit_d = 1'b0;
        for (int k = 0; k < LANES; k++) lane_d[k] = lane_q[k];
        if (rise && selValid) begin
            commit_d = 1'b1;
            for (int k = 0; k < LANES; k++) begin
                if (lane_sel == SEL_W'(k)) lane_d[k] = res;
            end
        end
    end

    // wrReq_q resets to 1 so a request held through reset must drop before it counts
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
            wrReq_q  <= 1'b1;
            commit_q <= 1'b0;
        end else begin
            for (int k = 0; k < LANES; k++) lane_q[k] <= lane_d[k];
            wrReq_q  <= wr_req;
            commit_q <= commit_d;
        end
    end

    assign commit = commit_q;

`ifdef GPIO_OUT_BLINK_EN
    gpio_blink_tick #(
        .DIV (BLINK_DIV)
    ) u_blink (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .phase    (blink_phase)
    );

    assign blankLane = blink_mask & {LANES{blink_phase}};
`else
    localparam int unusedBlinkDiv = BLINK_DIV;
    logic unusedBlinkMask;

    assign unusedBlinkMask = ^blink_mask;
    assign blink_phase     = 1'b0;
    assign blankLane       = '0;
`endif

    // Output composition: register value, blanked by blink, then preview on top
    always_comb begin
        gpio_out = '0;
        for (int k = 0; k < LANES; k++) begin
            if (preview_en && lane_sel == SEL_W'(k))
                gpio_out[k*LANE_W +: LANE_W] = res;
            else if (blankLane[k])
                gpio_out[k*LANE_W +: LANE_W] = '0;
            else
                gpio_out[k*LANE_W +: LANE_W] = lane_q[k];
        end
    end

endmodule

// File: tb/tb_gpio_out_bank.sv
// tb_gpio_out_bank
// Self-checking bench for gpio_out_bank. Two instances share stimulus: a
// four-lane bank and a three-lane bank (for the out-of-range select case).
// Each write pushes the expected full gpio_out image onto a per-instance
// queue; a monitor pops and compares whenever that instance pulses commit.
module tb_gpio_out_bank;
    import gpio_out_pkg::*;

    logic        CLOCK_50;
    logic        reset;
    logic [1:0]  laneSel;
    logic [7:0]  wrData;
    logic [1:0]  wrMode;
    logic        wrReq;
    logic        previewEn;
    logic [3:0]  blinkMask4;
    logic [2:0]  blinkMask3;
    logic [31:0] gpioOut4;
    logic [23:0] gpioOut3;
    logic        commit4, commit3;
    logic        phase4, phase3;

    logic [31:0] expQ4[$];
    logic [23:0] expQ3[$];
    int          testsRun;
    int          testsFailed;

    gpio_out_bank #(.LANES(4), .LANE_W(8), .BLINK_DIV(4)) dut4 (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .lane_sel    (laneSel),
        .wr_data     (wrData),
        .wr_mode     (wrMode),
        .wr_req      (wrReq),
        .preview_en  (previewEn),
        .blink_mask  (blinkMask4),
        .gpio_out    (gpioOut4),
        .commit      (commit4),
        .blink_phase (phase4)
    );

    gpio_out_bank #(.LANES(3), .LANE_W(8), .BLINK_DIV(4)) dut3 (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .lane_sel    (laneSel),
        .wr_data     (wrData),
        .wr_mode     (wrMode),
        .wr_req      (wrReq),
        .preview_en  (previewEn),
        .blink_mask  (blinkMask3),
        .gpio_out    (gpioOut3),
        .commit      (commit3),
        .blink_phase (phase3)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Monitor: every commit pulse must match the oldest outstanding write
    always @(negedge CLOCK_50) begin
        if (commit4 === 1'b1) begin
            testsRun++;
            if (expQ4.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL commit4_unexpected: got commit with gpio_out=%h, want no commit", gpioOut4);
            end else begin
                logic [31:0] e4;
                e4 = expQ4.pop_front();
                if (gpioOut4 !== e4) begin
                    testsFailed++;
                    $display("[TB] FAIL commit4_value: got %h, want %h", gpioOut4, e4);
                end
            end
        end
        if (commit3 === 1'b1) begin
            testsRun++;
            if (expQ3.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL commit3_unexpected: got commit with gpio_out=%h, want no commit", gpioOut3);
            end else begin
                logic [23:0] e3;
                e3 = expQ3.pop_front();
                if (gpioOut3 !== e3) begin
                    testsFailed++;
                    $display("[TB] FAIL commit3_value: got %h, want %h", gpioOut3, e3);
                end
            end
        end
    end

    // Direct comparison of a sampled value against a hand-computed constant
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Issue one write pulse and queue the expected images for each bank
    task automatic applyStimulus(input logic [1:0] sel, input logic [7:0] data,
                                 input logic [1:0] mode, input logic [31:0] exp4,
                                 input logic [23:0] exp3, input bit commits3);
        laneSel = sel;
        wrData  = data;
        wrMode  = mode;
        wrReq   = 1'b1;
        expQ4.push_back(exp4);
        if (commits3) expQ3.push_back(exp3);
        @(posedge CLOCK_50); #1;
        wrReq = 1'b0;
        @(posedge CLOCK_50); #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        laneSel     = '0;
        wrData      = '0;
        wrMode      = WR_LOAD;
        wrReq       = 1'b1;
        previewEn   = 1'b0;
        blinkMask4  = '0;
        blinkMask3  = '0;

        // Reset with the request held high; it must not commit after release
        waitCycles(3);
        reset = 1'b0;
        checkOutput("reset_gpio4", gpioOut4, 32'h0);
        checkOutput("reset_phase4", {31'b0, phase4}, 32'h0);
        checkOutput("reset_commit4", {31'b0, commit4}, 32'h0);
        waitCycles(5);
        checkOutput("held_req_gpio4", gpioOut4, 32'h0);
        checkOutput("held_req_gpio3", {8'h0, gpioOut3}, 32'h0);
        wrReq = 1'b0;
        waitCycles(1);

        // Lane 2 load, then the set/clear/toggle sequence on lane 0
        applyStimulus(2'd2, 8'hA5, WR_LOAD, 32'h00A50000, 24'hA50000, 1'b1);
        checkOutput("load_lane2", gpioOut4, 32'h00A50000);
        applyStimulus(2'd0, 8'hF0, WR_LOAD, 32'h00A500F0, 24'hA500F0, 1'b1);
        applyStimulus(2'd0, 8'h0F, WR_SET,  32'h00A500FF, 24'hA500FF, 1'b1);
        applyStimulus(2'd0, 8'h3C, WR_CLR,  32'h00A500C3, 24'hA500C3, 1'b1);
        applyStimulus(2'd0, 8'hFF, WR_TGL,  32'h00A5003C, 24'hA5003C, 1'b1);
        checkOutput("toggle_lane0", gpioOut4, 32'h00A5003C);

        // Preview without a request edge, then back off
        previewEn = 1'b1;
        laneSel   = 2'd1;
        wrData    = 8'h55;
        wrMode    = WR_LOAD;
        #1;
        checkOutput("preview_load_l1", gpioOut4, 32'h00A5553C);
        laneSel = 2'd2;
        wrData  = 8'hFF;
        wrMode  = WR_TGL;
        #1;
        checkOutput("preview_tgl_l2", gpioOut4, 32'h005A003C);
        previewEn = 1'b0;
        #1;
        checkOutput("preview_off", gpioOut4, 32'h00A5003C);
        waitCycles(2);
        checkOutput("preview_no_commit", gpioOut4, 32'h00A5003C);

        // Lane 3 is valid on the four-lane bank, out of range on the three-lane bank
        applyStimulus(2'd3, 8'h77, WR_LOAD, 32'h77A5003C, 24'h0, 1'b0);
        checkOutput("oob_lane3_gpio3", {8'h0, gpioOut3}, 32'h00A5003C);
        checkOutput("oob_lane3_gpio4", gpioOut4, 32'h77A5003C);

        applyStimulus(2'd0, 8'hFF, WR_LOAD, 32'h77A500FF, 24'hA500FF, 1'b1);
        blinkMask4 = 4'b0001;

`ifdef GPIO_OUT_BLINK_EN
        // Align to a 0->1 phase transition, then check one full blink period
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge CLOCK_50);
                if (phase4 === 1'b0) seen = 1'b1;
            end
            if (seen) begin
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge CLOCK_50);
                    if (phase4 === 1'b1) seen = 1'b1;
                end
            end
            testsRun++;
            if (!seen) begin
                testsFailed++;
                $display("[TB] FAIL blink_align: got no phase rise in 40 cycles, want a rise");
            end
        end
        for (int i = 0; i < 8; i++) begin
            checkOutput("blink_lane0", {24'h0, gpioOut4[7:0]}, (i < 4) ? 32'h00 : 32'hFF);
            checkOutput("blink_other", {8'h0, gpioOut4[31:8]}, 32'h0077A500);
            @(negedge CLOCK_50);
        end
        previewEn = 1'b1;
        laneSel   = 2'd0;
        wrData    = 8'h11;
        wrMode    = WR_LOAD;
        for (int i = 0; i < 8; i++) begin
            checkOutput("blink_preview", {24'h0, gpioOut4[7:0]}, 32'h11);
            @(negedge CLOCK_50);
        end
        previewEn = 1'b0;
`else
        // Without the blink engine the mask has no effect and phase stays 0
        for (int i = 0; i < 8; i++) begin
            checkOutput("noblink_lane0", gpioOut4, 32'h77A500FF);
            checkOutput("noblink_phase", {31'b0, phase4}, 32'h0);
            @(negedge CLOCK_50);
        end
`endif

        // Reset on the same edge as a request rise: reset wins
        @(posedge CLOCK_50); #1;
        blinkMask4 = '0;
        laneSel    = 2'd1;
        wrData     = 8'h99;
        wrMode     = WR_LOAD;
        wrReq      = 1'b1;
        reset      = 1'b1;
        @(posedge CLOCK_50); #1;
        reset = 1'b0;
        checkOutput("rst_rise_gpio4", gpioOut4, 32'h0);
        checkOutput("rst_rise_gpio3", {8'h0, gpioOut3}, 32'h0);
        checkOutput("rst_rise_phase", {31'b0, phase4}, 32'h0);
        waitCycles(3);
        checkOutput("rst_phase_e3", {31'b0, phase4}, 32'h0);
        waitCycles(1);
`ifdef GPIO_OUT_BLINK_EN
        checkOutput("rst_phase_e4", {31'b0, phase4}, 32'h1);
`else
        checkOutput("rst_phase_e4", {31'b0, phase4}, 32'h0);
`endif
        checkOutput("rst_held_gpio4", gpioOut4, 32'h0);
        wrReq = 1'b0;
        waitCycles(1);

        // Writes work again after the request has dropped
        applyStimulus(2'd3, 8'h42, WR_LOAD, 32'h42000000, 24'h0, 1'b0);
        applyStimulus(2'd1, 8'h81, WR_SET,  32'h42008100, 24'h008100, 1'b1);
        waitCycles(2);

        checkOutput("pending4", expQ4.size(), 32'd0);
        checkOutput("pending3", expQ3.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
